multiplier_adder3: RTL and testbench

- Unsigned 3x3-bit array multiplier producing a 6-bit product.
- Built structurally from AND-gate partial products and a half-adder/full-adder ripple array (no behavioural `*` operator).
- Wrapped in a two-stage registered pipeline with a valid flag, for use as a small arithmetic leaf inside datapath blocks.

---
 rtl/multiplier_adder3.sv | 109 ++++++++++
 tb/tb_multiplier_adder3.sv | 138 +++++++++++++
 2 files changed

// File: rtl/multiplier_adder3.sv
// rtl/multiplier_adder3.sv - unsigned 3x3 array multiplier in a two-stage valid pipeline
// Stage 1 registers AND-gate partial products; stage 2 sums them in an HA/FA ripple array.

module multiplier_adder3_ha (
    input  logic x,
    input  logic y,
    output logic sum,
    output logic carry
);
    assign sum   = x ^ y;
    assign carry = x & y;
endmodule

module multiplier_adder3_fa (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic sum,
    output logic carry
);
    assign sum   = x ^ y ^ z;
    assign carry = (x & y) | (x & z) | (y & z);
endmodule

module multiplier_adder3 (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [2:0] a,
    input  logic [2:0] b,
    output logic [5:0] p,
    output logic       out_valid
);
    // pp_q[i][j] = a[j] & b[i], weight 2^(i+j)
    logic [2:0][2:0] pp_d, pp_q;
    logic            v1_d, v1_q;
    logic [5:0]      p_d, p_q;
    logic            out_valid_d, out_valid_q;

    logic [5:0] sum_w;
    logic       r1_c1, r1_s2, r1_c2, r1_s3, r1_c3;
    logic       r2_c2, r2_c3;

    // Partial products hold while idle so X or toggling operands never reach the array.
    always_comb begin
        pp_d = pp_q;
        v1_d = in_valid;
        if (in_valid) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    pp_d[i][j] = a[j] & b[i];
                end
            end
        end
    end

    assign sum_w[0] = pp_q[0][0];

    // Row 1: pp[0][2:1] + pp[1][2:0]
    multiplier_adder3_ha u_r1_col1 (
        .x(pp_q[0][1]), .y(pp_q[1][0]),
        .sum(sum_w[1]), .carry(r1_c1)
    );
    multiplier_adder3_fa u_r1_col2 (
        .x(pp_q[0][2]), .y(pp_q[1][1]), .z(r1_c1),
        .sum(r1_s2), .carry(r1_c2)
    );
    multiplier_adder3_ha u_r1_col3 (
        .x(pp_q[1][2]), .y(r1_c2),
        .sum(r1_s3), .carry(r1_c3)
    );

    // Row 2: row-1 result + pp[2][2:0]; final carry is the product MSB
    multiplier_adder3_ha u_r2_col2 (
        .x(r1_s2), .y(pp_q[2][0]),
        .sum(sum_w[2]), .carry(r2_c2)
    );
    multiplier_adder3_fa u_r2_col3 (
        .x(r1_s3), .y(pp_q[2][1]), .z(r2_c2),
        .sum(sum_w[3]), .carry(r2_c3)
    );
    multiplier_adder3_fa u_r2_col4 (
        .x(r1_c3), .y(pp_q[2][2]), .z(r2_c3),
        .sum(sum_w[4]), .carry(sum_w[5])
    );

    always_comb begin
        p_d         = v1_q ? sum_w : p_q;
        out_valid_d = v1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pp_q        <= '0;
            v1_q        <= 1'b0;
            p_q         <= 6'd0;
            out_valid_q <= 1'b0;
        end else begin
            pp_q        <= pp_d;
            v1_q        <= v1_d;
            p_q         <= p_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign p         = p_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_multiplier_adder3.sv
// tb/tb_multiplier_adder3.sv - directed self-checking bench for multiplier_adder3

module tb_multiplier_adder3;
    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [2:0] a;
    logic [2:0] b;
    logic [5:0] p;
    logic       out_valid;

    int n_checks;
    int n_fails;

    // expected pipeline: one stage between input capture and output register
    bit         mv1;
    logic [5:0] mp1;
    logic [5:0] hold_p;
    bit         ov_exp;

    multiplier_adder3 dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .a(a),
        .b(b),
        .p(p),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d (%b) expected %0d (%b) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    // Called just after a rising edge: drive inputs, advance one edge, check outputs.
    task automatic cycle(input bit iv, input logic [2:0] ia, input logic [2:0] ib, input logic [5:0] ep);
        in_valid = iv;
        a        = ia;
        b        = ib;
        @(posedge clk);
        #1;
        ov_exp = mv1;
        if (mv1) hold_p = mp1;
        mv1 = iv;
        mp1 = ep;
        check_eq("out_valid", {5'd0, out_valid}, {5'd0, ov_exp});
        check_eq("p", p, hold_p);
    endtask

    // Asynchronous reset pulse between edges; outputs must clear with no clock.
    task automatic pulse_rst(input string tag);
        #2 rst = 1'b1;
        #1;
        check_eq({tag, "_ov"}, {5'd0, out_valid}, 6'd0);
        check_eq({tag, "_p"}, p, 6'd0);
        #2 rst = 1'b0;
        mv1    = 1'b0;
        hold_p = 6'd0;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        mv1      = 1'b0;
        mp1      = 6'd0;
        hold_p   = 6'd0;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = 3'd0;
        b        = 3'd0;

        #1;
        check_eq("rst_ov", {5'd0, out_valid}, 6'd0);
        check_eq("rst_p", p, 6'd0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_hold_p", p, 6'd0);
        rst = 1'b0;

        cycle(0, 3'd0, 3'd0, 6'd0);

        // directed products, back-to-back
        cycle(1, 3'd7, 3'd5, 6'd35);
        cycle(1, 3'd6, 3'd5, 6'd30);
        cycle(1, 3'd6, 3'd3, 6'd18);
        cycle(1, 3'd5, 3'd5, 6'd25);
        cycle(1, 3'd2, 3'd6, 6'd12);
        // extremes
        cycle(1, 3'd7, 3'd7, 6'd49);
        cycle(1, 3'd0, 3'd7, 6'd0);
        cycle(1, 3'd7, 3'd0, 6'd0);
        cycle(1, 3'd1, 3'd1, 6'd1);
        cycle(1, 3'd4, 3'd4, 6'd16);
        // bubble: X operands while idle must not disturb p
        cycle(1, 3'd3, 3'd3, 6'd9);
        cycle(0, 3'bxxx, 3'bxxx, 6'd0);
        cycle(1, 3'd2, 3'd5, 6'd10);
        cycle(0, 3'd7, 3'd7, 6'd0);
        cycle(0, 3'bxxx, 3'bxxx, 6'd0);
        cycle(0, 3'd0, 3'd0, 6'd0);

        // reset with pipeline full and out_valid high
        cycle(1, 3'd7, 3'd7, 6'd49);
        cycle(1, 3'd1, 3'd1, 6'd1);
        cycle(1, 3'd6, 3'd5, 6'd30);
        pulse_rst("rst_full");
        cycle(0, 3'd0, 3'd0, 6'd0);
        cycle(0, 3'd0, 3'd0, 6'd0);

        // mid-operation reset: (7,5) discarded, then (6,3)
        cycle(1, 3'd7, 3'd5, 6'd35);
        pulse_rst("rst_mid");
        cycle(0, 3'd0, 3'd0, 6'd0);
        cycle(1, 3'd6, 3'd3, 6'd18);
        cycle(0, 3'd0, 3'd0, 6'd0);
        cycle(0, 3'd0, 3'd0, 6'd0);
        cycle(0, 3'd0, 3'd0, 6'd0);

        // exhaustive stream
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                cycle(1, 3'(i), 3'(j), 6'(i * j));
            end
        end
        repeat (3) cycle(0, 3'd0, 3'd0, 6'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
